// File: rtl/lock_supervisor.sv
// -----------------------------------------------------------------------------
// lock_supervisor
//
// Supervisory controller wrapped around the A/B/C combination-sequence
// detector. It edge-detects the synchronised button levels, forwards single
// cycle press pulses to the detector, clears the detector whenever an attempt
// ends (timeout, too many presses, or a completed opening), holds the door
// actuator enabled for a fixed window and enforces a lockout after repeated
// failed attempts.
//
// Ports
//   clk         in   system clock, all logic on the rising edge
//   rst         in   synchronous, active-high reset
//   btn_a/b/c   in   synchronised button levels
//   fsm_unlock  in   unlock output of the sequence detector
//   det_a/b/c   out  one-cycle press pulses to the detector (registered)
//   det_clr     out  one-cycle synchronous clear to the detector (registered)
//   unlock_out  out  actuator enable, high for OPEN_CYCLES cycles (registered)
//   locked_out  out  high while in LOCKOUT (registered)
//   fail_cnt    out  consecutive failed-attempt count, saturates at MAX_FAILS
//   state_dbg   out  IDLE=0, ENTRY=1, OPEN=2, LOCKOUT=3
// -----------------------------------------------------------------------------
module lock_supervisor #(
    parameter int ENTRY_TIMEOUT  = 64,
    parameter int MAX_PRESSES    = 4,
    parameter int OPEN_CYCLES    = 32,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           btn_a,
    input  logic                           btn_b,
    input  logic                           btn_c,
    input  logic                           fsm_unlock,
    output logic                           det_a,
    output logic                           det_b,
    output logic                           det_c,
    output logic                           det_clr,
    output logic                           unlock_out,
    output logic                           locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
    output logic [1:0]                     state_dbg
);

    // -------------------------------------------------------------------------
    // Widths and terminal values. Every counter is sized to hold exactly its
    // terminal value, and each one stops (or is reloaded) on reaching it, so
    // none of them can wrap.
    // -------------------------------------------------------------------------
    localparam int TW = $clog2(ENTRY_TIMEOUT);
    localparam int PW = $clog2(MAX_PRESSES + 1);
    localparam int OW = $clog2(OPEN_CYCLES);
    localparam int LW = $clog2(LOCKOUT_CYCLES);
    localparam int FW = $clog2(MAX_FAILS + 1);

    localparam logic [TW-1:0] TMO_LAST   = TW'(ENTRY_TIMEOUT - 1);
    localparam logic [PW-1:0] PRESS_MAX  = PW'(MAX_PRESSES);
    localparam logic [OW-1:0] OPEN_LAST  = OW'(OPEN_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);

    // State encoding is visible on state_dbg, so it is fixed here.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ENTRY   = 2'd1;
    localparam logic [1:0] S_OPEN    = 2'd2;
    localparam logic [1:0] S_LOCKOUT = 2'd3;

    logic [1:0]    state;
    logic [2:0]    btn;        // {a, b, c}
    logic [2:0]    btn_q;      // previous-cycle button levels
    logic [2:0]    press;      // rising edges this cycle
    logic          press_any;
    logic [TW-1:0] tmo_cnt;    // idle cycles since the last accepted press
    logic [PW-1:0] press_cnt;  // presses accepted in the current attempt
    logic [OW-1:0] open_cnt;
    logic [LW-1:0] lock_cnt;

    // Decision terms evaluated in the current cycle.
    logic          timeout_hit;
    logic          press_over;
    logic          entry_fail;
    logic          forward;
    logic [FW-1:0] fail_next;

    assign btn       = {btn_a, btn_b, btn_c};
    assign press     = btn & ~btn_q;
    assign press_any = |press;
    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // Attempt bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so
        // no path leaves one unassigned and no latch is inferred.
        timeout_hit = 1'b0;
        press_over  = 1'b0;
        entry_fail  = 1'b0;
        forward     = 1'b0;
        fail_next   = fail_cnt;

        timeout_hit = (tmo_cnt == TMO_LAST);
        press_over  = (press_cnt == PRESS_MAX);

        // A detector unlock outranks everything else in ENTRY. A new press
        // restarts the idle timer, so it also outranks the timeout: the only
        // press that fails an attempt is one that would exceed the limit.
        if (state == S_ENTRY && !fsm_unlock) begin
            if (press_any) begin
                entry_fail = press_over;
            end else begin
                entry_fail = timeout_hit;
            end
        end

        // Presses reach the detector only while an attempt can still use them:
        // never alongside an unlock and never as the press that fails it.
        case (state)
            S_IDLE:  forward = press_any;
            S_ENTRY: forward = press_any && !fsm_unlock && !press_over;
            default: forward = 1'b0;
        endcase

        if (fail_cnt != FAIL_LIMIT) begin
            fail_next = fail_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignment so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state      <= S_IDLE;
            // NOTE: the edge history loads the live button levels rather than
            // zero, so a button held through reset does not count as a press.
            btn_q      <= btn;
            tmo_cnt    <= '0;
            press_cnt  <= '0;
            open_cnt   <= '0;
            lock_cnt   <= '0;
            fail_cnt   <= '0;
            det_a      <= 1'b0;
            det_b      <= 1'b0;
            det_c      <= 1'b0;
            det_clr    <= 1'b0;
            unlock_out <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            btn_q <= btn;

            // Simultaneous edges travel together as one press event.
            {det_a, det_b, det_c} <= forward ? press : 3'b000;
            det_clr               <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (press_any) begin
                        state     <= S_ENTRY;
                        press_cnt <= PW'(1);
                        tmo_cnt   <= '0;
                    end
                end

                S_ENTRY: begin
                    if (fsm_unlock) begin
                        state      <= S_OPEN;
                        unlock_out <= 1'b1;
                        open_cnt   <= '0;
                        fail_cnt   <= '0;
                    end else if (entry_fail) begin
                        det_clr  <= 1'b1;
                        fail_cnt <= fail_next;
                        if (fail_next == FAIL_LIMIT) begin
                            state      <= S_LOCKOUT;
                            locked_out <= 1'b1;
                            lock_cnt   <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (press_any) begin
                        press_cnt <= press_cnt + 1'b1;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                // fsm_unlock is deliberately not looked at here: the detector
                // stays asserted until it is cleared at the end of the window.
                S_OPEN: begin
                    if (open_cnt == OPEN_LAST) begin
                        state      <= S_IDLE;
                        unlock_out <= 1'b0;
                        det_clr    <= 1'b1;
                    end else begin
                        open_cnt <= open_cnt + 1'b1;
                    end
                end

                // Presses are neither forwarded nor counted, and cannot touch
                // lock_cnt, so the window length is fixed.
                S_LOCKOUT: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state      <= S_IDLE;
                        locked_out <= 1'b0;
                        fail_cnt   <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_lock_supervisor
//
// Directed bench for lock_supervisor. Stimulus pushes each expected output
// event (cycle stamp, det pulses, det_clr, unlock/locked, state, fail count)
// into a queue; a monitor on the falling edge pops and compares whenever the
// DUT emits a pulse or changes unlock_out/locked_out. A small A-A-B detector
// model drives fsm_unlock, with an override used to place an unlock on an
// exact cycle.
// -----------------------------------------------------------------------------
module tb_lock_supervisor;

    localparam logic [2:0] BA = 3'b100;
    localparam logic [2:0] BB = 3'b010;
    localparam logic [2:0] BC = 3'b001;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  det;
        logic        clr;
        logic        unl;
        logic        lck;
        logic [1:0]  st;
        logic [1:0]  fc;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       btn_a, btn_b, btn_c;
    logic       fsm_unlock;
    logic       det_a, det_b, det_c;
    logic       det_clr;
    logic       unlock_out;
    logic       locked_out;
    logic [1:0] fail_cnt;
    logic [1:0] state_dbg;

    logic [31:0] cyc;
    logic [1:0]  stage;
    logic        force_unlock;
    logic        prev_unl;
    logic        prev_lck;
    ev_t         exp_q[$];
    int          n_cmp;
    int          n_err;

    lock_supervisor dut (
        .clk        (clk),
        .rst        (rst),
        .btn_a      (btn_a),
        .btn_b      (btn_b),
        .btn_c      (btn_c),
        .fsm_unlock (fsm_unlock),
        .det_a      (det_a),
        .det_b      (det_b),
        .det_c      (det_c),
        .det_clr    (det_clr),
        .unlock_out (unlock_out),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt),
        .state_dbg  (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= (cyc === 'x) ? 32'd1 : cyc + 32'd1;
    initial cyc = 32'd0;

    // Detector model: accepts A, A, B and then holds unlock until cleared.
    always @(posedge clk) begin
        if (rst || det_clr) begin
            stage <= 2'd0;
        end else if (det_a | det_b | det_c) begin
            if      (stage == 2'd0 && {det_a, det_b, det_c} == BA) stage <= 2'd1;
            else if (stage == 2'd1 && {det_a, det_b, det_c} == BA) stage <= 2'd2;
            else if (stage == 2'd2 && {det_a, det_b, det_c} == BB) stage <= 2'd3;
            else if ({det_a, det_b, det_c} == BA)                  stage <= 2'd1;
            else                                                   stage <= 2'd0;
        end
    end

    assign fsm_unlock = (stage == 2'd3) | force_unlock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] m);
        {btn_a, btn_b, btn_c} = m;
        tick(1);
        {btn_a, btn_b, btn_c} = 3'b000;
    endtask

    task automatic expect_ev(input int dc, input logic [2:0] det, input logic clr,
                             input logic unl, input logic lck, input logic [1:0] st,
                             input logic [1:0] fc);
        ev_t e;
        e.cyc = cyc + 32'(dc);
        e.det = det;
        e.clr = clr;
        e.unl = unl;
        e.lck = lck;
        e.st  = st;
        e.fc  = fc;
        exp_q.push_back(e);
    endtask

    task automatic check_quiet(input string tag, input logic [1:0] st, input logic [1:0] fc);
        check({tag, "_outputs"}, {det_a, det_b, det_c, det_clr, unlock_out, locked_out}, 0);
        check({tag, "_state"}, state_dbg, st);
        check({tag, "_fail_cnt"}, fail_cnt, fc);
    endtask

    // Monitor: one queue entry per observed output event.
    always @(negedge clk) begin
        ev_t act;
        ev_t exp;
        if (!rst && (det_a || det_b || det_c || det_clr ||
                     unlock_out != prev_unl || locked_out != prev_lck)) begin
            act = '{cyc, {det_a, det_b, det_c}, det_clr, unlock_out, locked_out,
                    state_dbg, fail_cnt};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: got %0h, expected no event (cycle %0d)",
                         act, cyc);
            end else begin
                exp = exp_q.pop_front();
                check("event", 64'(act), 64'(exp));
            end
        end
        prev_unl <= unlock_out;
        prev_lck <= locked_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        force_unlock = 1'b0;
        prev_unl     = 1'b0;
        prev_lck     = 1'b0;

        // 1. Reset with btn_a held: nothing comes out, no press after release.
        rst = 1'b1;
        {btn_a, btn_b, btn_c} = 3'b100;
        tick(2);
        check_quiet("reset", 2'd0, 2'd0);
        rst = 1'b0;
        tick(5);
        check_quiet("held_btn", 2'd0, 2'd0);
        btn_a = 1'b0;
        tick(3);

        // 2. Correct entry A, A, B; unlock two edges after det_b, 32-cycle window.
        expect_ev(1,  BA, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
        expect_ev(6,  BA, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
        expect_ev(11, BB, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
        expect_ev(13, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0);
        expect_ev(45, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        press(BA); tick(4);
        press(BA); tick(4);
        press(BB); tick(40);
        check_quiet("after_open", 2'd0, 2'd0);

        // 3. Single press then idle: clear 64 edges after the press edge.
        expect_ev(1,  BA, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
        expect_ev(65, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1);
        press(BA); tick(70);
        check_quiet("after_timeout", 2'd0, 2'd1);

        // 4. Three attempts of five C presses each -> lockout.
        rst = 1'b1; tick(2); rst = 1'b0; tick(1);
        check_quiet("reset2", 2'd0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                expect_ev(1, BC, 1'b0, 1'b0, 1'b0, 2'd1, 2'(k));
                press(BC); tick(3);
            end
            expect_ev(1, 3'b000, 1'b1, 1'b0, (k == 2), (k == 2) ? 2'd3 : 2'd0, 2'(k + 1));
            press(BC);
            if (k < 2) tick(3);
        end
        // Lockout began on the edge just taken; it ends 256 edges later.
        expect_ev(256, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        tick(4);
        press(BB);          // early in the window
        tick(250);
        press(BB);          // lands on the exit edge, still dropped
        tick(5);
        check_quiet("after_lockout", 2'd0, 2'd0);

        // 5. Unlock on the exact timeout boundary wins.
        expect_ev(1, BA, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
        press(BA);
        tick(63);
        expect_ev(1, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0);
        force_unlock = 1'b1;
        tick(1);
        force_unlock = 1'b0;
        expect_ev(32, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        tick(40);

        // 6. Reset at OPEN cycle 10 aborts the window.
        expect_ev(1, BA, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
        press(BA);
        expect_ev(1, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0);
        force_unlock = 1'b1;
        tick(1);
        force_unlock = 1'b0;
        tick(10);
        rst = 1'b1;
        tick(1);
        check_quiet("reset_mid_open", 2'd0, 2'd0);
        tick(1);
        rst = 1'b0;
        tick(40);
        check_quiet("after_abort", 2'd0, 2'd0);

        check("pending_events", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
